// File: rtl/vec_mem_sequencer_if.sv
// vec_mem_sequencer_if: scalar, vector and data-memory signals around the vector memory sequencer.
interface vec_mem_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LANE_W     = 16,
  parameter int LANES      = 16
);
  localparam int VEC_W = LANE_W * LANES;
  logic                  sreq;
  logic                  swe;
  logic [ADDR_WIDTH-1:0] saddr;
  logic [LANE_W-1:0]     swdata;
  logic                  sgnt;
  logic [LANE_W-1:0]     srdata;
  logic                  vreq;
  logic                  vwe;
  logic [ADDR_WIDTH-1:0] vaddr;
  logic [VEC_W-1:0]      vwdata;
  logic [VEC_W-1:0]      vrdata;
  logic                  vdone;
  logic                  stall;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LANE_W-1:0]     mem_wdata;
  logic [LANE_W-1:0]     mem_rdata;
  modport slave (
    input  sreq, swe, saddr, swdata, vreq, vwe, vaddr, vwdata, mem_rdata,
    output sgnt, srdata, vrdata, vdone, stall, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output sreq, swe, saddr, swdata, vreq, vwe, vaddr, vwdata, mem_rdata,
    input  sgnt, srdata, vrdata, vdone, stall, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: runs 256-bit vector loads/stores as lane beats over the shared scalar data-memory port.
module vec_mem_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LANE_W     = 16,
  parameter int LANES      = 16,
  parameter int STRIDE     = 2
) (
  input logic             clk,
  input logic             reset,
  vec_mem_sequencer_if.slave bus
);
  localparam int VEC_W = LANE_W * LANES;
  localparam int CW    = $clog2(LANES);
  typedef enum logic [2:0] {IDLE, VREAD, VWRITE, VDRAIN, DONE} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic [VEC_W-1:0]      wdata;
  logic [VEC_W-1:0]      rdata;
  logic                  done;
  logic                  idle;
  logic                  last;
  always_comb begin
    idle          = state == IDLE;
    last          = cnt == CW'(LANES - 1);
    bus.stall     = idle ? bus.vreq : state != DONE;
    bus.sgnt      = idle & ~bus.vreq & bus.sreq;
    bus.srdata    = bus.mem_rdata;
    bus.vrdata    = rdata;
    bus.vdone     = done;
    // an asserted reset must never let a write through, even for a scalar request
    bus.mem_we    = ~reset & (idle ? bus.sgnt & bus.swe : state == VWRITE);
    bus.mem_addr  = idle ? bus.saddr : base + ADDR_WIDTH'(cnt) * ADDR_WIDTH'(STRIDE);
    bus.mem_wdata = idle ? bus.swdata : wdata[cnt*LANE_W +: LANE_W];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      wdata <= '0;
      rdata <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.vreq) begin
          base  <= bus.vaddr & ~ADDR_WIDTH'(1);
          wdata <= bus.vwdata;
          cnt   <= '0;
          state <= bus.vwe ? VWRITE : VREAD;
        end
        // read data lags the address by one beat, so each beat lands the previous lane
        VREAD: begin
          if (cnt != '0) rdata[(cnt - 1'b1)*LANE_W +: LANE_W] <= bus.mem_rdata;
          cnt <= cnt + 1'b1;
          if (last) state <= VDRAIN;
        end
        VDRAIN: begin
          rdata[(LANES-1)*LANE_W +: LANE_W] <= bus.mem_rdata;
          done  <= 1'b1;
          state <= DONE;
        end
        VWRITE: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: directed vectors with a queued scoreboard for memory writes, scalar reads and vector completions.
module tb_vec_mem_sequencer;
  logic clk;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  logic [47:0]  wq[$];
  logic [255:0] dq[$];
  logic [15:0]  rq[$];
  logic [15:0]  mem[logic [31:0]];
  logic         srd_pend = 1'b0;
  int stalls, done_at, ndone, gnt_at;
  logic sg0;
  vec_mem_sequencer_if b ();
  vec_mem_sequencer dut (.clk(clk), .reset(reset), .bus(b.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  function automatic logic [255:0] mkvec(input logic [15:0] s);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = s + 16'(i);
    return v;
  endfunction
  task automatic push_writes(input logic [31:0] a, input logic [255:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ad;
      ad = a + 32'(2 * i);
      wq.push_back({ad, d[i*16 +: 16]});
    end
  endtask
  // data memory with one-cycle read latency
  always @(posedge clk) begin
    b.mem_rdata <= mem.exists(b.mem_addr) ? mem[b.mem_addr] : 16'h0;
    if (b.mem_we) mem[b.mem_addr] = b.mem_wdata;
  end
  always @(negedge clk) begin
    if (srd_pend) begin
      if (rq.size() == 0) check("srdata_unexpected", 1, 0);
      else check("srdata", b.srdata, rq.pop_front());
    end
    srd_pend = b.sgnt && !b.swe;
    if (b.mem_we) begin
      if (wq.size() == 0) check("mem_write_unexpected", {b.mem_addr, b.mem_wdata}, 0);
      else check("mem_write", {b.mem_addr, b.mem_wdata}, wq.pop_front());
    end
    if (b.vdone) begin
      if (dq.size() == 0) check("vdone_unexpected", 1, 0);
      else check("vrdata_at_vdone", b.vrdata, dq.pop_front());
    end
  end
  task automatic vec_op(input logic we, input logic [31:0] a, input logic [255:0] d, input logic hold,
                        output int st, output int dn, output int nd, output logic g0, output int ga);
    logic g;
    b.vreq = 1'b1; b.vwe = we; b.vaddr = a; b.vwdata = d;
    st = 0; dn = -1; nd = 0; ga = -1; g0 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      g = b.sgnt;
      if (c == 0) g0 = g;
      if (g && ga < 0) ga = c;
      if (b.stall) st++;
      if (b.vdone) begin
        nd++;
        if (dn < 0) dn = c;
      end
      @(posedge clk); #1;
      if (!hold || dn >= 0) b.vreq = 1'b0;
      if (g) b.sreq = 1'b0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    b.sreq = 1'b1; b.swe = 1'b1; b.saddr = 32'h0; b.swdata = 16'h0;
    b.vreq = 1'b0; b.vwe = 1'b0; b.vaddr = 32'h0; b.vwdata = '0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) mem[32'h100 + 32'(2 * i)] = 16'h1000 + 16'(i);
    repeat (2) @(posedge clk);
    #2;
    check("reset_mem_we", b.mem_we, 0);
    check("reset_stall", b.stall, 0);
    check("reset_vdone", b.vdone, 0);
    check("reset_vrdata", b.vrdata, 0);
    b.sreq = 1'b0; b.swe = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    wq.push_back({32'h40, 16'hBEEF});
    b.sreq = 1'b1; b.swe = 1'b1; b.saddr = 32'h40; b.swdata = 16'hBEEF;
    #1;
    check("swrite_sgnt", b.sgnt, 1);
    check("swrite_stall", b.stall, 0);
    @(posedge clk); #1;
    rq.push_back(16'hBEEF);
    b.swe = 1'b0;
    #1;
    check("sread_sgnt", b.sgnt, 1);
    check("sread_stall", b.stall, 0);
    @(posedge clk); #1 b.sreq = 1'b0;
    @(posedge clk); #1;
    dq.push_back(mkvec(16'h1000));
    vec_op(1'b0, 32'h101, '0, 1'b0, stalls, done_at, ndone, sg0, gnt_at);
    check("load_stalls", stalls, 18);
    check("load_done_at", done_at, 18);
    check("load_ndone", ndone, 1);
    push_writes(32'h200, mkvec(16'hA000), 16);
    dq.push_back(mkvec(16'h1000));
    vec_op(1'b1, 32'h200, mkvec(16'hA000), 1'b0, stalls, done_at, ndone, sg0, gnt_at);
    check("store_stalls", stalls, 17);
    check("store_done_at", done_at, 17);
    check("store_keeps_vrdata", b.vrdata, mkvec(16'h1000));
    dq.push_back(mkvec(16'hA000));
    vec_op(1'b0, 32'h200, '0, 1'b0, stalls, done_at, ndone, sg0, gnt_at);
    check("readback_done_at", done_at, 18);
    b.sreq = 1'b1; b.swe = 1'b0; b.saddr = 32'h40;
    rq.push_back(16'hBEEF);
    dq.push_back(mkvec(16'h1000));
    vec_op(1'b0, 32'h100, '0, 1'b0, stalls, done_at, ndone, sg0, gnt_at);
    check("arb_sgnt_first", sg0, 0);
    check("arb_grant_after_done", gnt_at, 19);
    check("arb_stalls", stalls, 18);
    push_writes(32'hFFFF_FFF0, mkvec(16'h5000), 16);
    dq.push_back(mkvec(16'h1000));
    vec_op(1'b1, 32'hFFFF_FFF0, mkvec(16'h5000), 1'b1, stalls, done_at, ndone, sg0, gnt_at);
    check("hold_ndone", ndone, 1);
    check("hold_stalls", stalls, 17);
    check("wrap_lane8", mem.exists(32'h0) ? mem[32'h0] : 16'h0, 16'h5008);
    dq.push_back(mkvec(16'h5000));
    vec_op(1'b0, 32'hFFFF_FFF0, '0, 1'b0, stalls, done_at, ndone, sg0, gnt_at);
    check("wrap_load_ndone", ndone, 1);
    push_writes(32'h300, mkvec(16'hC000), 5);
    b.vreq = 1'b1; b.vwe = 1'b1; b.vaddr = 32'h300; b.vwdata = mkvec(16'hC000);
    @(posedge clk); #1 b.vreq = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_mem_we", b.mem_we, 0);
    check("abort_stall", b.stall, 0);
    check("abort_vrdata", b.vrdata, 0);
    check("abort_vdone", b.vdone, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_stall", b.stall, 0);
    check("abort_lane5_unwritten", mem.exists(32'h30A), 0);
    check("abort_lane4_written", mem.exists(32'h308) ? mem[32'h308] : 16'h0, 16'hC004);
    repeat (3) @(posedge clk);
    #1;
    check("wq_drained", wq.size(), 0);
    check("dq_drained", dq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
